// File: rtl/axi_lite_slave_pkg.sv
// Shared types and constants for the AXI4-Lite slave to local register bus bridge.
package axi_lite_slave_pkg;

  localparam int unsigned LCL_ADDR_W = 32;
  localparam int unsigned LCL_DATA_W = 32;
  localparam int unsigned LCL_STRB_W = LCL_DATA_W / 8;
  localparam int unsigned TMO_CNT_W  = 32;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_REQ,
    ST_WR_WAIT,
    ST_WR_RESP,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_RD_RESP
  } state_e;

  // Held write request: address from AW, data/strobes from W.
  typedef struct packed {
    logic [LCL_ADDR_W-1:0] addr;
    logic [LCL_DATA_W-1:0] data;
    logic [LCL_STRB_W-1:0] strb;
  } wr_req_t;

  // Counter preload so that expiry lands on the Nth wait cycle; 0 means unused.
  function automatic logic [TMO_CNT_W-1:0] tmo_load_val(input int unsigned cycles);
    if (cycles == 0) return '0;
    return TMO_CNT_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/axi_lite_slave_timeout.sv
// Loadable down-counter: clear, load, count while enabled, expired when enabled at zero.
module axi_lite_slave_timeout
  import axi_lite_slave_pkg::*;
#(
  parameter int unsigned CNT_W = TMO_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             expired_c
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign expired_c = en && (cnt == '0);

endmodule

// File: rtl/axi_lite_slave.sv
// AXI4-Lite slave issuing single-cycle strobes on a local register bus, one transaction
// in flight, with round-robin write/read arbitration and a response timeout.
module axi_lite_slave
  import axi_lite_slave_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter logic [31:0] TIMEOUT_RDATA  = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [31:0] s_axi_awaddr,
  input  logic [2:0]  s_axi_awprot,
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  input  logic [31:0] s_axi_wdata,
  input  logic [3:0]  s_axi_wstrb,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready,
  output logic [1:0]  s_axi_bresp,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  input  logic [31:0] s_axi_araddr,
  input  logic [2:0]  s_axi_arprot,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready,
  output logic [31:0] s_axi_rdata,
  output logic [1:0]  s_axi_rresp,
  output logic        lcl_wr,
  output logic        lcl_rd,
  output logic [31:0] lcl_addr,
  output logic [31:0] lcl_din,
  output logic [3:0]  lcl_wstrb,
  input  logic        lcl_ack,
  input  logic [31:0] lcl_dout,
  input  logic        lcl_dv,
  input  logic        lcl_err
);

  state_e state, state_nxt;

  logic                  aw_held, w_held, ar_held, rd_prio;
  logic                  aw_held_nxt, w_held_nxt, ar_held_nxt, rd_prio_nxt;
  wr_req_t               wr_hold, wr_hold_nxt;
  logic [LCL_ADDR_W-1:0] ar_addr, ar_addr_nxt;

  logic                  awready_nxt, wready_nxt, arready_nxt;
  logic                  bvalid_nxt, rvalid_nxt;
  logic [1:0]            bresp_nxt, rresp_nxt;
  logic [LCL_DATA_W-1:0] rdata_nxt;
  logic                  lcl_wr_nxt, lcl_rd_nxt;
  logic [LCL_ADDR_W-1:0] lcl_addr_nxt;
  logic [LCL_DATA_W-1:0] lcl_din_nxt;
  logic [LCL_STRB_W-1:0] lcl_wstrb_nxt;

  logic aw_hs_c, w_hs_c, ar_hs_c;
  logic wr_pend_c, rd_pend_c;
  logic dispatch_wr_c, dispatch_rd_c;
  logic tmo_en_c, tmo_expired_c;

  logic unused_prot;
  assign unused_prot = ^{s_axi_awprot, s_axi_arprot};

  assign aw_hs_c   = s_axi_awvalid & s_axi_awready;
  assign w_hs_c    = s_axi_wvalid  & s_axi_wready;
  assign ar_hs_c   = s_axi_arvalid & s_axi_arready;
  assign wr_pend_c = (aw_held | aw_hs_c) & (w_held | w_hs_c);
  assign rd_pend_c = ar_held | ar_hs_c;

  assign dispatch_wr_c = (state == ST_IDLE) && (state_nxt == ST_WR_REQ);
  assign dispatch_rd_c = (state == ST_IDLE) && (state_nxt == ST_RD_REQ);

  assign tmo_en_c = ((state == ST_WR_WAIT) || (state == ST_RD_WAIT)) && (TIMEOUT_CYCLES != 0);

  axi_lite_slave_timeout #(
    .CNT_W (TMO_CNT_W)
  ) u_timeout (
    .clk       (clk),
    .rst       (rst),
    .clr       (state == ST_IDLE),
    .load      ((state == ST_WR_REQ) || (state == ST_RD_REQ)),
    .load_val  (tmo_load_val(TIMEOUT_CYCLES)),
    .en        (tmo_en_c),
    .expired_c (tmo_expired_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next state; a real local response takes precedence over a same-cycle timeout.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (wr_pend_c && (!rd_pend_c || !rd_prio)) state_nxt = ST_WR_REQ;
        else if (rd_pend_c)                        state_nxt = ST_RD_REQ;
      end
      ST_WR_REQ:  state_nxt = ST_WR_WAIT;
      ST_WR_WAIT: if (lcl_ack || tmo_expired_c) state_nxt = ST_WR_RESP;
      ST_WR_RESP: if (s_axi_bready) state_nxt = ST_IDLE;
      ST_RD_REQ:  state_nxt = ST_RD_WAIT;
      ST_RD_WAIT: if (lcl_dv || tmo_expired_c) state_nxt = ST_RD_RESP;
      ST_RD_RESP: if (s_axi_rready) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Next values of the holding registers and of every registered output.
  always_comb begin
    aw_held_nxt   = aw_held | aw_hs_c;
    w_held_nxt    = w_held | w_hs_c;
    ar_held_nxt   = (ar_held | ar_hs_c) & ~dispatch_rd_c;
    wr_hold_nxt   = wr_hold;
    ar_addr_nxt   = ar_addr;
    rd_prio_nxt   = rd_prio;
    bresp_nxt     = s_axi_bresp;
    rresp_nxt     = s_axi_rresp;
    rdata_nxt     = s_axi_rdata;
    lcl_addr_nxt  = lcl_addr;
    lcl_din_nxt   = lcl_din;
    lcl_wstrb_nxt = lcl_wstrb;

    if (aw_hs_c) wr_hold_nxt.addr = s_axi_awaddr;
    if (w_hs_c) begin
      wr_hold_nxt.data = s_axi_wdata;
      wr_hold_nxt.strb = s_axi_wstrb;
    end
    if (ar_hs_c) ar_addr_nxt = s_axi_araddr;

    if ((state == ST_WR_RESP) && s_axi_bready) begin
      aw_held_nxt = 1'b0;
      w_held_nxt  = 1'b0;
    end

    if (dispatch_wr_c) begin
      rd_prio_nxt   = 1'b1;
      lcl_addr_nxt  = wr_hold_nxt.addr;
      lcl_din_nxt   = wr_hold_nxt.data;
      lcl_wstrb_nxt = wr_hold_nxt.strb;
    end else if (dispatch_rd_c) begin
      rd_prio_nxt  = 1'b0;
      lcl_addr_nxt = ar_addr_nxt;
    end

    if (state == ST_WR_WAIT) begin
      if (lcl_ack)            bresp_nxt = lcl_err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
      else if (tmo_expired_c) bresp_nxt = AXI_RESP_SLVERR;
    end

    if (state == ST_RD_WAIT) begin
      if (lcl_dv) begin
        rdata_nxt = lcl_dout;
        rresp_nxt = lcl_err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
      end else if (tmo_expired_c) begin
        rdata_nxt = TIMEOUT_RDATA;
        rresp_nxt = AXI_RESP_SLVERR;
      end
    end

    awready_nxt = (state_nxt == ST_IDLE) && !aw_held_nxt;
    wready_nxt  = (state_nxt == ST_IDLE) && !w_held_nxt;
    arready_nxt = (state_nxt == ST_IDLE) && !ar_held_nxt &&
                  (!(aw_held_nxt && w_held_nxt) || rd_prio_nxt);
    bvalid_nxt  = (state_nxt == ST_WR_RESP);
    rvalid_nxt  = (state_nxt == ST_RD_RESP);
    lcl_wr_nxt  = dispatch_wr_c;
    lcl_rd_nxt  = dispatch_rd_c;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_held       <= 1'b0;
      w_held        <= 1'b0;
      ar_held       <= 1'b0;
      rd_prio       <= 1'b0;
      wr_hold       <= '0;
      ar_addr       <= '0;
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_arready <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bresp   <= AXI_RESP_OKAY;
      s_axi_rvalid  <= 1'b0;
      s_axi_rdata   <= '0;
      s_axi_rresp   <= AXI_RESP_OKAY;
      lcl_wr        <= 1'b0;
      lcl_rd        <= 1'b0;
      lcl_addr      <= '0;
      lcl_din       <= '0;
      lcl_wstrb     <= '0;
    end else begin
      aw_held       <= aw_held_nxt;
      w_held        <= w_held_nxt;
      ar_held       <= ar_held_nxt;
      rd_prio       <= rd_prio_nxt;
      wr_hold       <= wr_hold_nxt;
      ar_addr       <= ar_addr_nxt;
      s_axi_awready <= awready_nxt;
      s_axi_wready  <= wready_nxt;
      s_axi_arready <= arready_nxt;
      s_axi_bvalid  <= bvalid_nxt;
      s_axi_bresp   <= bresp_nxt;
      s_axi_rvalid  <= rvalid_nxt;
      s_axi_rdata   <= rdata_nxt;
      s_axi_rresp   <= rresp_nxt;
      lcl_wr        <= lcl_wr_nxt;
      lcl_rd        <= lcl_rd_nxt;
      lcl_addr      <= lcl_addr_nxt;
      lcl_din       <= lcl_din_nxt;
      lcl_wstrb     <= lcl_wstrb_nxt;
    end
  end

endmodule

// File: tb/tb_axi_lite_slave.sv
// Directed self-checking bench for axi_lite_slave with a hand-driven local bus.
module tb_axi_lite_slave;

  localparam int unsigned TMO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_axi_awvalid, s_axi_awready;
  logic [31:0] s_axi_awaddr;
  logic [2:0]  s_axi_awprot;
  logic        s_axi_wvalid, s_axi_wready;
  logic [31:0] s_axi_wdata;
  logic [3:0]  s_axi_wstrb;
  logic        s_axi_bvalid, s_axi_bready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_arvalid, s_axi_arready;
  logic [31:0] s_axi_araddr;
  logic [2:0]  s_axi_arprot;
  logic        s_axi_rvalid, s_axi_rready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        lcl_wr, lcl_rd;
  logic [31:0] lcl_addr, lcl_din;
  logic [3:0]  lcl_wstrb;
  logic        lcl_ack, lcl_dv, lcl_err;
  logic [31:0] lcl_dout;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   wr_cnt = 0;
  int   rd_cnt = 0;
  logic dual = 1'b0;

  axi_lite_slave #(
    .TIMEOUT_CYCLES (TMO),
    .TIMEOUT_RDATA  (32'hDEAD_BEEF)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axi_awvalid (s_axi_awvalid),
    .s_axi_awready (s_axi_awready),
    .s_axi_awaddr  (s_axi_awaddr),
    .s_axi_awprot  (s_axi_awprot),
    .s_axi_wvalid  (s_axi_wvalid),
    .s_axi_wready  (s_axi_wready),
    .s_axi_wdata   (s_axi_wdata),
    .s_axi_wstrb   (s_axi_wstrb),
    .s_axi_bvalid  (s_axi_bvalid),
    .s_axi_bready  (s_axi_bready),
    .s_axi_bresp   (s_axi_bresp),
    .s_axi_arvalid (s_axi_arvalid),
    .s_axi_arready (s_axi_arready),
    .s_axi_araddr  (s_axi_araddr),
    .s_axi_arprot  (s_axi_arprot),
    .s_axi_rvalid  (s_axi_rvalid),
    .s_axi_rready  (s_axi_rready),
    .s_axi_rdata   (s_axi_rdata),
    .s_axi_rresp   (s_axi_rresp),
    .lcl_wr        (lcl_wr),
    .lcl_rd        (lcl_rd),
    .lcl_addr      (lcl_addr),
    .lcl_din       (lcl_din),
    .lcl_wstrb     (lcl_wstrb),
    .lcl_ack       (lcl_ack),
    .lcl_dout      (lcl_dout),
    .lcl_dv        (lcl_dv),
    .lcl_err       (lcl_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (lcl_wr && lcl_rd) dual <= 1'b1;
    if (lcl_wr) wr_cnt <= wr_cnt + 1;
    if (lcl_rd) rd_cnt <= rd_cnt + 1;
  end

  task automatic clear_inputs();
    s_axi_awvalid = 1'b0; s_axi_awaddr = '0; s_axi_awprot = '0;
    s_axi_wvalid  = 1'b0; s_axi_wdata  = '0; s_axi_wstrb  = '0;
    s_axi_bready  = 1'b0;
    s_axi_arvalid = 1'b0; s_axi_araddr = '0; s_axi_arprot = '0;
    s_axi_rready  = 1'b0;
    lcl_ack = 1'b0; lcl_dv = 1'b0; lcl_err = 1'b0; lcl_dout = '0;
  endtask

  // Local-bus responder for one transaction: ack/dv in the first wait cycle, then take the AXI response.
  task automatic serve_one(input logic err, input logic [31:0] rd_val,
                           output logic is_rd, output logic [31:0] addr,
                           output logic [1:0] resp, output logic [31:0] rdata, output logic ok);
    int n = 0;
    ok = 1'b1; is_rd = 1'b0; addr = '0; resp = '0; rdata = '0;
    while (!(lcl_wr || lcl_rd) && n < 40) begin @(negedge clk); n++; end
    if (n >= 40) begin ok = 1'b0; return; end
    is_rd = lcl_rd;
    addr  = lcl_addr;
    @(negedge clk);
    lcl_err = err;
    if (is_rd) begin lcl_dv = 1'b1; lcl_dout = rd_val; end
    else       lcl_ack = 1'b1;
    @(negedge clk);
    lcl_ack = 1'b0; lcl_dv = 1'b0; lcl_err = 1'b0; lcl_dout = '0;
    s_axi_bready = 1'b1; s_axi_rready = 1'b1;
    n = 0;
    while (!(s_axi_bvalid || s_axi_rvalid) && n < 40) begin @(negedge clk); n++; end
    if (n >= 40) ok = 1'b0;
    resp  = is_rd ? s_axi_rresp : s_axi_bresp;
    rdata = s_axi_rdata;
    @(negedge clk);
    s_axi_bready = 1'b0; s_axi_rready = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid, lcl_wr, lcl_rd} !== 7'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b want 0000000",
        {s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid, lcl_wr, lcl_rd});
    end
    checks++;
    if ({lcl_addr, lcl_din, lcl_wstrb, s_axi_rdata, s_axi_bresp, s_axi_rresp} !== 104'b0) begin
      errors++; $display("FAIL reset_data: addr=%h din=%h rdata=%h want all zero", lcl_addr, lcl_din, s_axi_rdata);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({s_axi_awready, s_axi_wready, s_axi_arready} !== 3'b111) begin
      errors++; $display("FAIL reset_release_ready: got %b want 111", {s_axi_awready, s_axi_wready, s_axi_arready});
    end
  endtask

  task automatic test_same_cycle_write();
    s_axi_awvalid = 1'b1; s_axi_awaddr = 32'h10;
    s_axi_wvalid = 1'b1;  s_axi_wdata = 32'hA5A5_0001; s_axi_wstrb = 4'hF;
    @(negedge clk);
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    checks++;
    if ({lcl_wr, lcl_addr, lcl_din, lcl_wstrb} !== {1'b1, 32'h10, 32'hA5A5_0001, 4'hF}) begin
      errors++; $display("FAIL same_cycle_strobe: wr=%b addr=%h din=%h strb=%h want 1 00000010 a5a50001 f",
        lcl_wr, lcl_addr, lcl_din, lcl_wstrb);
    end
    checks++;
    if ({s_axi_awready, s_axi_wready, s_axi_arready} !== 3'b000) begin
      errors++; $display("FAIL same_cycle_busy_ready: got %b want 000", {s_axi_awready, s_axi_wready, s_axi_arready});
    end
    @(negedge clk);
    checks++;
    if (lcl_wr !== 1'b0) begin errors++; $display("FAIL same_cycle_pulse: lcl_wr=%b want 0", lcl_wr); end
    @(negedge clk);
    lcl_ack = 1'b1;
    checks++;
    if (s_axi_bvalid !== 1'b0) begin errors++; $display("FAIL same_cycle_early_b: bvalid=%b want 0", s_axi_bvalid); end
    @(negedge clk);
    lcl_ack = 1'b0; s_axi_bready = 1'b1;
    checks++;
    if ({s_axi_bvalid, s_axi_bresp} !== 3'b100) begin
      errors++; $display("FAIL same_cycle_bresp: bvalid=%b bresp=%b want 1 00", s_axi_bvalid, s_axi_bresp);
    end
    @(negedge clk);
    s_axi_bready = 1'b0;
    checks++;
    if ({s_axi_bvalid, s_axi_awready} !== 2'b01) begin
      errors++; $display("FAIL same_cycle_done: bvalid=%b awready=%b want 0 1", s_axi_bvalid, s_axi_awready);
    end
  endtask

  task automatic test_w_before_aw();
    int wr0 = wr_cnt;
    s_axi_wvalid = 1'b1; s_axi_wdata = 32'h0000_BEEF; s_axi_wstrb = 4'b0011;
    @(negedge clk);
    s_axi_wvalid = 1'b0;
    checks++;
    if ({s_axi_wready, s_axi_awready} !== 2'b01) begin
      errors++; $display("FAIL w_first_ready: wready=%b awready=%b want 0 1", s_axi_wready, s_axi_awready);
    end
    repeat (2) begin
      @(negedge clk);
      checks++;
      if ({lcl_wr, s_axi_wready} !== 2'b00) begin
        errors++; $display("FAIL w_first_wait: lcl_wr=%b wready=%b want 0 0", lcl_wr, s_axi_wready);
      end
    end
    s_axi_awvalid = 1'b1; s_axi_awaddr = 32'h20;
    @(negedge clk);
    s_axi_awvalid = 1'b0;
    checks++;
    if ({lcl_wr, lcl_addr, lcl_din, lcl_wstrb} !== {1'b1, 32'h20, 32'h0000_BEEF, 4'b0011}) begin
      errors++; $display("FAIL w_first_strobe: wr=%b addr=%h din=%h strb=%b want 1 00000020 0000beef 0011",
        lcl_wr, lcl_addr, lcl_din, lcl_wstrb);
    end
    @(negedge clk);
    lcl_ack = 1'b1;
    @(negedge clk);
    lcl_ack = 1'b0; s_axi_bready = 1'b1;
    checks++;
    if ({s_axi_bvalid, s_axi_bresp} !== 3'b100) begin
      errors++; $display("FAIL w_first_bresp: bvalid=%b bresp=%b want 1 00", s_axi_bvalid, s_axi_bresp);
    end
    @(negedge clk);
    s_axi_bready = 1'b0;
    checks++;
    if (wr_cnt - wr0 != 1) begin errors++; $display("FAIL w_first_count: strobes=%0d want 1", wr_cnt - wr0); end
  endtask

  task automatic test_read_error_backpressure();
    s_axi_arvalid = 1'b1; s_axi_araddr = 32'h30;
    @(negedge clk);
    s_axi_arvalid = 1'b0;
    checks++;
    if ({lcl_rd, lcl_addr} !== {1'b1, 32'h30}) begin
      errors++; $display("FAIL rd_err_strobe: rd=%b addr=%h want 1 00000030", lcl_rd, lcl_addr);
    end
    @(negedge clk);
    lcl_dv = 1'b1; lcl_dout = 32'h1234_5678; lcl_err = 1'b1;
    @(negedge clk);
    lcl_dv = 1'b0; lcl_dout = '0; lcl_err = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({s_axi_rvalid, s_axi_rdata, s_axi_rresp} !== {1'b1, 32'h1234_5678, 2'b10}) begin
        errors++; $display("FAIL rd_err_hold%0d: rvalid=%b rdata=%h rresp=%b want 1 12345678 10",
          i, s_axi_rvalid, s_axi_rdata, s_axi_rresp);
      end
      @(negedge clk);
    end
    s_axi_rready = 1'b1;
    @(negedge clk);
    s_axi_rready = 1'b0;
    checks++;
    if (s_axi_rvalid !== 1'b0) begin errors++; $display("FAIL rd_err_release: rvalid=%b want 0", s_axi_rvalid); end
  endtask

  task automatic test_read_timeout();
    int rd_c;
    int n = 0;
    s_axi_arvalid = 1'b1; s_axi_araddr = 32'h40;
    @(negedge clk);
    s_axi_arvalid = 1'b0;
    rd_c = cyc;
    checks++;
    if (lcl_rd !== 1'b1) begin errors++; $display("FAIL tmo_strobe: lcl_rd=%b want 1", lcl_rd); end
    while (s_axi_rvalid !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    checks++;
    if (s_axi_rvalid !== 1'b1 || cyc != rd_c + 9) begin
      errors++; $display("FAIL tmo_latency: rvalid=%b after %0d cycles want 1 after 9", s_axi_rvalid, cyc - rd_c);
    end
    checks++;
    if ({s_axi_rdata, s_axi_rresp} !== {32'hDEAD_BEEF, 2'b10}) begin
      errors++; $display("FAIL tmo_data: rdata=%h rresp=%b want deadbeef 10", s_axi_rdata, s_axi_rresp);
    end
    lcl_dv = 1'b1; lcl_dout = 32'h1111_1111;
    @(negedge clk);
    lcl_dv = 1'b0; lcl_dout = '0;
    @(negedge clk);
    checks++;
    if ({s_axi_rvalid, s_axi_rdata, s_axi_rresp} !== {1'b1, 32'hDEAD_BEEF, 2'b10}) begin
      errors++; $display("FAIL tmo_late_dv: rvalid=%b rdata=%h rresp=%b want 1 deadbeef 10",
        s_axi_rvalid, s_axi_rdata, s_axi_rresp);
    end
    s_axi_rready = 1'b1;
    @(negedge clk);
    s_axi_rready = 1'b0;
    lcl_ack = 1'b1; lcl_dv = 1'b1;
    @(negedge clk);
    lcl_ack = 1'b0; lcl_dv = 1'b0;
    @(negedge clk);
    checks++;
    if ({s_axi_bvalid, s_axi_rvalid, lcl_wr, lcl_rd, s_axi_awready, s_axi_arready} !== 6'b000011) begin
      errors++; $display("FAIL tmo_spurious: b=%b r=%b wr=%b rd=%b awr=%b arr=%b want 0 0 0 0 1 1",
        s_axi_bvalid, s_axi_rvalid, lcl_wr, lcl_rd, s_axi_awready, s_axi_arready);
    end
  endtask

  task automatic test_back_to_back();
    logic        is_rd, ok;
    logic [31:0] addr, rdata;
    logic [1:0]  resp;
    for (int p = 0; p < 2; p++) begin
      checks++;
      if ({s_axi_awready, s_axi_wready, s_axi_arready} !== 3'b111) begin
        errors++; $display("FAIL b2b_ready%0d: got %b want 111", p, {s_axi_awready, s_axi_wready, s_axi_arready});
      end
      s_axi_awvalid = 1'b1; s_axi_awaddr = 32'h100 + 32'(p * 16);
      s_axi_wvalid = 1'b1;  s_axi_wdata = 32'hCAFE_0000 + 32'(p); s_axi_wstrb = 4'hF;
      s_axi_arvalid = 1'b1; s_axi_araddr = 32'h200 + 32'(p * 16);
      @(negedge clk);
      s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
      serve_one(p == 1, 32'h0, is_rd, addr, resp, rdata, ok);
      checks++;
      if ({ok, is_rd, addr, resp} !== {1'b1, 1'b0, 32'h100 + 32'(p * 16), (p == 1) ? 2'b10 : 2'b00}) begin
        errors++; $display("FAIL b2b_first%0d: ok=%b is_rd=%b addr=%h resp=%b want write first", p, ok, is_rd, addr, resp);
      end
      serve_one(1'b0, 32'hC0DE_0000 + 32'(p), is_rd, addr, resp, rdata, ok);
      checks++;
      if ({ok, is_rd, addr, resp, rdata} !== {1'b1, 1'b1, 32'h200 + 32'(p * 16), 2'b00, 32'hC0DE_0000 + 32'(p)}) begin
        errors++; $display("FAIL b2b_second%0d: ok=%b is_rd=%b addr=%h resp=%b rdata=%h want read second",
          p, ok, is_rd, addr, resp, rdata);
      end
      @(negedge clk);
    end
    checks++;
    if (dual !== 1'b0) begin errors++; $display("FAIL b2b_dual_strobe: dual=%b want 0", dual); end
  endtask

  task automatic test_reset_mid_write();
    logic        is_rd, ok;
    logic [31:0] addr, rdata;
    logic [1:0]  resp;
    s_axi_awvalid = 1'b1; s_axi_awaddr = 32'h60;
    s_axi_wvalid = 1'b1;  s_axi_wdata = 32'h6666_6666; s_axi_wstrb = 4'hF;
    @(negedge clk);
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid, lcl_wr, lcl_rd, lcl_addr} !== 39'b0) begin
      errors++; $display("FAIL midrst_outputs: ctrl=%b addr=%h want all zero",
        {s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid, lcl_wr, lcl_rd}, lcl_addr);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({s_axi_bvalid, s_axi_awready, s_axi_wready} !== 3'b011) begin
      errors++; $display("FAIL midrst_recover: bvalid=%b awready=%b wready=%b want 0 1 1",
        s_axi_bvalid, s_axi_awready, s_axi_wready);
    end
    s_axi_awvalid = 1'b1; s_axi_awaddr = 32'h70;
    s_axi_wvalid = 1'b1;  s_axi_wdata = 32'h7777_7777; s_axi_wstrb = 4'hF;
    @(negedge clk);
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    serve_one(1'b0, 32'h0, is_rd, addr, resp, rdata, ok);
    checks++;
    if ({ok, is_rd, addr, resp} !== {1'b1, 1'b0, 32'h70, 2'b00}) begin
      errors++; $display("FAIL midrst_next_write: ok=%b is_rd=%b addr=%h resp=%b want 1 0 00000070 00",
        ok, is_rd, addr, resp);
    end
  endtask

  initial begin
    test_reset();
    test_same_cycle_write();
    test_w_before_aw();
    test_read_error_backpressure();
    test_read_timeout();
    test_back_to_back();
    test_reset_mid_write();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axi_lite_slave.md
Name: axi_lite_slave

Overview:
AXI4-Lite slave that terminates a host-side AXI-Lite bus and drives a simple local register bus. It issues single-cycle lcl_wr/lcl_rd strobes and collects the lcl_ack/lcl_dv completions. It sits in front of action/status register files and is the counterpart of the local-bus-to-AXI-Lite master bridge. One transaction is in flight at a time. A timeout guarantees an AXI response even if the local side never answers.

Parameters:
TIMEOUT_CYCLES, 256, cycles to wait for lcl_ack/lcl_dv before forcing SLVERR; 0 disables the timeout.
TIMEOUT_RDATA, 32'hDEAD_BEEF, rdata returned on a read timeout.

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  reset, asynchronous, active-high
s_axi_awvalid  in  1  write address valid
s_axi_awready  out  1  write address ready
s_axi_awaddr  in  32  write address
s_axi_awprot  in  3  ignored
s_axi_wvalid  in  1  write data valid
s_axi_wready  out  1  write data ready
s_axi_wdata  in  32  write data
s_axi_wstrb  in  4  byte strobes
s_axi_bvalid  out  1  write response valid
s_axi_bready  in  1  write response ready
s_axi_bresp  out  2  00 OKAY, 10 SLVERR
s_axi_arvalid  in  1  read address valid
s_axi_arready  out  1  read address ready
s_axi_araddr  in  32  read address
s_axi_arprot  in  3  ignored
s_axi_rvalid  out  1  read data valid
s_axi_rready  in  1  read data ready
s_axi_rdata  out  32  read data
s_axi_rresp  out  2  00 OKAY, 10 SLVERR
lcl_wr  out  1  one-cycle write strobe
lcl_rd  out  1  one-cycle read strobe
lcl_addr  out  32  address, valid with strobe, held until completion
lcl_din  out  32  write data, valid with lcl_wr
lcl_wstrb  out  4  byte enables, valid with lcl_wr
lcl_ack  in  1  write done pulse
lcl_dout  in  32  read data, valid with lcl_dv
lcl_dv  in  1  read data valid pulse
lcl_err  in  1  sampled with lcl_ack/lcl_dv; 1 = error, giving SLVERR

Behaviour:
- Reset: every output is 0; the FSM is in IDLE; the priority flag selects write; both holding registers are empty.
- FSM states: IDLE, WR_REQ, WR_WAIT, WR_RESP, RD_REQ, RD_WAIT, RD_RESP.
- In IDLE:
  - s_axi_awready = 1 while no AW is held; s_axi_wready = 1 while no W is held. AW and W are latched independently, in any order or in the same cycle.
  - s_axi_arready = 1 only in IDLE, and only when no complete AW+W pair is held (or is being completed this cycle) unless read has priority.
- Arbitration: when a write pair and an AR are both ready in the same IDLE cycle, round-robin applies. The last-served flag is updated on each dispatch.
- WR_REQ: lasts one cycle. lcl_wr = 1 with lcl_addr, lcl_din and lcl_wstrb. Go to WR_WAIT.
- WR_WAIT: on lcl_ack, bresp = lcl_err ? 10 : 00 and go to WR_RESP. The first WR_WAIT cycle may already see lcl_ack.
- WR_RESP: s_axi_bvalid = 1, held until s_axi_bready. Then clear the holding registers and return to IDLE.
- RD_REQ / RD_WAIT / RD_RESP mirror the write path:
  - lcl_rd pulses for one cycle.
  - On lcl_dv, capture lcl_dout and lcl_err.
  - s_axi_rvalid is held until s_axi_rready.
- Latency: AW+W accepted at edge N means lcl_wr is high in cycle N+1. A local response sampled at edge M means bvalid/rvalid are high from cycle M+1. Minimum AXI-to-AXI latency is 3 cycles.
- Timeout:
  - The counter runs in WR_WAIT/RD_WAIT and clears on state entry.
  - When it reaches TIMEOUT_CYCLES, respond with SLVERR. A read timeout returns rdata = TIMEOUT_RDATA.
  - If a response and the timeout occur in the same cycle, the real response wins.
- lcl_ack/lcl_dv outside the matching WAIT state (late, spurious or wrong type) are ignored.
- bvalid/rvalid never drop without the matching ready. Response data is stable while valid.
- Reset asserted mid-transaction aborts it immediately with no response; the bus master is also reset.

Decomposition:
- Shared package holds:
  - the state enum
  - the AXI_RESP_OKAY = 2'b00 and AXI_RESP_SLVERR = 2'b10 constants
  - the local-bus width constants
- One natural sub-module, axi_lite_slave_timeout: a loadable down-counter with clear, enable and expired outputs, reused by other bridges.

Test Plan:
- AW 0x10 and W 0xA5A5_0001 in the same cycle, lcl_ack after 2 cycles -> lcl_wr in the next cycle with addr 0x10 and din 0xA5A5_0001; bvalid with bresp 00.
- W arrives 3 cycles before AW 0x20 -> wready drops after the W handshake; exactly one lcl_wr with addr 0x20.
- AR 0x30, lcl_dv with dout 0x1234_5678 and lcl_err = 1, rready held low for 4 cycles -> rvalid stays high and stable with rdata 0x1234_5678 and rresp 10.
- AR with no lcl_dv, TIMEOUT_CYCLES = 8 -> rvalid 9 cycles after lcl_rd with rdata 0xDEAD_BEEF and rresp 10. A late lcl_dv is then ignored.
- Write pair and AR presented together in back-to-back pairs -> service order write, read, write, read; never two strobes in one cycle.
- rst raised during WR_WAIT -> all outputs 0 next cycle, no bvalid; a subsequent write completes normally.
